ula_seq_ctrl: RTL and testbench



---
 rtl/ula_pkg.sv | 38 +++
 rtl/ula_seq_ctrl_if.sv | 38 +++
 rtl/ula.sv | 38 +++
 rtl/ula_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_ula_seq_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared constants and types for the ULA sequencing controller
//
// Purpose: ULA control codes, controller opcodes, FSM state type and the
// default datapath width, plus a small opcode-classification helper.
// Ports: none (package).

package ula_pkg;

  localparam int WIDTH = 9;

  // ULAControl encodings understood by the combinational ULA
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_NOR = 3'b011;
  localparam logic [2:0] ULA_XOR = 3'b100;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_SLT = 3'b111;

  // Controller opcodes that are not a single ULA pass
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_RESP
  } state_t;

  // Opcodes 0000-0111 map straight onto ULAControl, except the hole at 0101.
  function automatic logic is_direct(input logic [3:0] op);
    return (op[3] == 1'b0) && (op[2:0] != 3'b101);
  endfunction

endpackage

// File: rtl/ula_seq_ctrl_if.sv
// rtl/ula_seq_ctrl_if.sv - request/response handshake bundle for the ULA sequencer
//
// Purpose: groups the request and response valid/ready channels.
// Ports (signals):
//   req_valid/req_ready/req_op/req_a/req_b            request channel
//   resp_valid/resp_ready/resp_data/resp_aux/
//   resp_zero/resp_dbz/resp_err                       response channel
// Modports: master = requester/consumer side, slave = controller side.

interface ula_seq_ctrl_if #(
  parameter int WIDTH = 9
);

  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [WIDTH-1:0] resp_aux;
  logic             resp_zero;
  logic             resp_dbz;
  logic             resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_aux, resp_zero, resp_dbz, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_aux, resp_zero, resp_dbz, resp_err
  );

endinterface

// File: rtl/ula.sv
// rtl/ula.sv - 9-bit combinational ULA driven by the sequencer
//
// Purpose: AND/OR/ADD/NOR/XOR/SUB/SLT on two operands; SLT is unsigned.
// Ports:
//   srca, srcb  in  WIDTH  operands
//   ctrl        in  3      ULAControl
//   result      out WIDTH  ULAResult
//   z           out 1      result == 0

module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ula_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             z
);

  always_comb begin
    result = '0;
    case (ctrl)
      ULA_AND: result = srca & srcb;
      ULA_OR:  result = srca | srcb;
      ULA_ADD: result = srca + srcb;
      ULA_NOR: result = ~(srca | srcb);
      ULA_XOR: result = srca ^ srcb;
      ULA_SUB: result = srca - srcb;
      ULA_SLT: result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      default: result = '0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/ula_seq_ctrl.sv
// rtl/ula_seq_ctrl.sv - sequencing initiator that drives the ULA and builds MUL/DIV
//
// Purpose: accepts one operation at a time, runs it on the external ULA
// (single pass, shift-add MUL, or restoring DIV) and presents the response.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus (slave)                request/response handshake bundle
//   ula_srca, ula_srcb         registered operands to the ULA
//   ula_ctrl                   registered ULAControl (never 101)
//   ula_result, ula_z          combinational ULA outputs

module ula_seq_ctrl
  import ula_pkg::*;
#(
  parameter int WIDTH = ula_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  ula_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] ula_srca,
  output logic [WIDTH-1:0] ula_srcb,
  output logic [2:0]       ula_ctrl,
  input  logic [WIDTH-1:0] ula_result,
  input  logic             ula_z
);

  localparam int           CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic             ge, ge_d;

  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] srca_d, srcb_d;
  logic [2:0]       ctrl_d;

  logic [CW-1:0]    idx;     // dividend bit consumed this DIV iteration
  logic [CW-1:0]    nxt;     // next loop index
  logic [WIDTH-1:0] rem_s;   // shifted partial remainder
  logic [WIDTH-1:0] rem_n;   // remainder after the conditional subtract
  logic [WIDTH-1:0] quo_n;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_aux   = aux_q;
  assign bus.resp_zero  = zero_q;
  assign bus.resp_dbz   = dbz_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      ge       <= 1'b0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      aux_q    <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
      err_q    <= 1'b0;
      ula_srca <= '0;
      ula_srcb <= '0;
      ula_ctrl <= ULA_AND;
    end else begin
      state    <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt      <= cnt_d;
      rem      <= rem_d;
      quo      <= quo_d;
      ge       <= ge_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      aux_q    <= aux_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      err_q    <= err_d;
      ula_srca <= srca_d;
      ula_srcb <= srcb_d;
      ula_ctrl <= ctrl_d;
    end
  end

  // ULA inputs are registered, so each state computes the operands the ULA
  // must see in the *next* cycle. In MUL the ula_srca register doubles as the
  // running accumulator.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt;
    rem_d   = rem;
    quo_d   = quo;
    ge_d    = ge;
    data_d  = data_q;
    aux_d   = aux_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    err_d   = err_q;
    srca_d  = '0;
    srcb_d  = '0;
    ctrl_d  = ULA_AND;

    idx   = LAST - cnt;
    nxt   = cnt + CW'(1);
    rem_s = {rem[WIDTH-2:0], a_q[idx]};
    rem_n = ge ? ula_result : rem;
    quo_n = ge ? (quo | (WIDTH'(1) << idx)) : quo;

    case (state)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          a_d    = bus.req_a;
          b_d    = bus.req_b;
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = '0;
          ge_d   = 1'b0;
          data_d = '0;
          aux_d  = '0;
          zero_d = 1'b1;
          dbz_d  = 1'b0;
          err_d  = 1'b0;
          if (is_direct(bus.req_op)) begin
            state_d = S_EXEC;
            srca_d  = bus.req_a;
            srcb_d  = bus.req_b;
            ctrl_d  = bus.req_op[2:0];
          end else if (bus.req_op == OP_MUL) begin
            state_d = S_MUL;
            srca_d  = '0;
            srcb_d  = bus.req_b[0] ? bus.req_a : '0;
            ctrl_d  = ULA_ADD;
          end else if (bus.req_op == OP_DIV) begin
            if (bus.req_b == '0) begin
              state_d = S_RESP;
              data_d  = '1;
              aux_d   = bus.req_a;
              zero_d  = 1'b0;
              dbz_d   = 1'b1;
            end else begin
              state_d = S_DIV_CMP;
              srca_d  = {{(WIDTH-1){1'b0}}, bus.req_a[WIDTH-1]};
              srcb_d  = bus.req_b;
              ctrl_d  = ULA_SLT;
            end
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end

      S_EXEC: begin
        data_d  = ula_result;
        zero_d  = ula_z;
        state_d = S_RESP;
      end

      S_MUL: begin
        if (cnt == LAST) begin
          data_d  = ula_result;
          zero_d  = (ula_result == '0);
          state_d = S_RESP;
        end else begin
          cnt_d  = nxt;
          srca_d = ula_result;
          srcb_d = b_q[nxt] ? (a_q << nxt) : '0;
          ctrl_d = ULA_ADD;
        end
      end

      S_DIV_CMP: begin
        // SLT gives 1 when rem_s < b, so "greater or equal" is its inverse
        ge_d    = ~ula_result[0];
        rem_d   = rem_s;
        srca_d  = rem_s;
        srcb_d  = b_q;
        ctrl_d  = ULA_SUB;
        state_d = S_DIV_SUB;
      end

      S_DIV_SUB: begin
        rem_d = rem_n;
        quo_d = quo_n;
        if (cnt == LAST) begin
          data_d  = quo_n;
          aux_d   = rem_n;
          zero_d  = (quo_n == '0);
          state_d = S_RESP;
        end else begin
          cnt_d   = nxt;
          srca_d  = {rem_n[WIDTH-2:0], a_q[idx - CW'(1)]};
          srcb_d  = b_q;
          ctrl_d  = ULA_SLT;
          state_d = S_DIV_CMP;
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// tb/tb_ula_seq_ctrl.sv - self-checking bench for the ULA sequencing controller

module tb_ula_seq_ctrl;

  localparam int W   = 9;
  localparam int LIM = 40;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] srca, srcb, result;
  logic [2:0]   ctrl;
  logic         z;

  int n_checks = 0;
  int n_fail   = 0;
  int bad_ctrl = 0;

  ula_seq_ctrl_if #(.WIDTH(W)) bus ();

  ula_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ula_srca  (srca),
    .ula_srcb  (srcb),
    .ula_ctrl  (ctrl),
    .ula_result(result),
    .ula_z     (z)
  );

  ula #(.WIDTH(W)) u_ula (
    .srca  (srca),
    .srcb  (srcb),
    .ctrl  (ctrl),
    .result(result),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ctrl === 3'b101) bad_ctrl++;

  // Reference behaviour computed with plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] d, output logic [W-1:0] x,
                                output logic zf, output logic dz, output logic er, output int lat);
    int unsigned ua;
    int unsigned ub;
    ua = a; ub = b;
    d = '0; x = '0; dz = 1'b0; er = 1'b0; lat = 2;
    case (op)
      4'd0: d = a & b;
      4'd1: d = a | b;
      4'd2: d = W'(ua + ub);
      4'd3: d = ~(a | b);
      4'd4: d = a ^ b;
      4'd6: d = W'(ua - ub);
      4'd7: d = (ua < ub) ? W'(1) : W'(0);
      4'd8: begin d = W'((ua * ub) % 512); lat = 10; end
      4'd9: begin
        if (ub == 0) begin d = '1; x = a; dz = 1'b1; lat = 1; end
        else begin d = W'(ua / ub); x = W'(ua % ub); lat = 19; end
      end
      default: begin er = 1'b1; lat = 1; end
    endcase
    zf = (d == '0);
  endfunction

  // Drives one request, measures cycles from acceptance to resp_valid,
  // captures the response, optionally stalls, then completes the handshake.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall,
                       output logic [W-1:0] d, output logic [W-1:0] x,
                       output logic zf, output logic dz, output logic er, output int lat);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < LIM) begin @(negedge clk); t++; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < LIM) begin @(posedge clk); #1; lat++; end
    d = bus.resp_data; x = bus.resp_aux; zf = bus.resp_zero;
    dz = bus.resp_dbz; er = bus.resp_err;
    repeat (stall) begin @(posedge clk); #1; end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_checks++; if ({bus.resp_data, bus.resp_aux, bus.resp_zero, bus.resp_dbz, bus.resp_err} !== {18'd0, 3'b100})
      begin n_fail++; $display("FAIL reset_resp got=%h/%h z%b d%b e%b exp=0/0 z1 d0 e0", bus.resp_data, bus.resp_aux, bus.resp_zero, bus.resp_dbz, bus.resp_err); end
    n_checks++; if ({srca, srcb, ctrl} !== 21'd0) begin n_fail++; $display("FAIL reset_ula got=%h/%h/%b exp=0/0/000", srca, srcb, ctrl); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_direct();
    logic [W-1:0] d, x; logic zf, dz, er; int lat;
    issue(4'd2, 9'h0FF, 9'h001, 0, d, x, zf, dz, er, lat);
    n_checks++; if (d !== 9'h100) begin n_fail++; $display("FAIL add_data got=%h exp=100", d); end
    n_checks++; if (zf !== 1'b0) begin n_fail++; $display("FAIL add_zero got=%b exp=0", zf); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got=%0d exp=2", lat); end
    issue(4'd6, 9'd5, 9'd5, 0, d, x, zf, dz, er, lat);
    n_checks++; if ({d, zf} !== {9'd0, 1'b1}) begin n_fail++; $display("FAIL sub_zero got=%h z%b exp=0 z1", d, zf); end
    issue(4'd7, 9'd3, 9'd9, 0, d, x, zf, dz, er, lat);
    n_checks++; if (d !== 9'd1) begin n_fail++; $display("FAIL slt got=%h exp=1", d); end
  endtask

  task automatic test_mul();
    logic [W-1:0] d, x; logic zf, dz, er; int lat;
    issue(4'd8, 9'd23, 9'd21, 0, d, x, zf, dz, er, lat);
    n_checks++; if (d !== 9'h1E3) begin n_fail++; $display("FAIL mul_23x21 got=%h exp=1e3", d); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL mul_latency got=%0d exp=10", lat); end
    issue(4'd8, 9'd30, 9'd20, 1, d, x, zf, dz, er, lat);
    n_checks++; if ({d, x, er} !== {9'd88, 9'd0, 1'b0}) begin n_fail++; $display("FAIL mul_wrap got=%0d aux=%0d err=%b exp=88 aux=0 err=0", d, x, er); end
  endtask

  task automatic test_div();
    logic [W-1:0] d, x; logic zf, dz, er; int lat;
    issue(4'd9, 9'd500, 9'd7, 0, d, x, zf, dz, er, lat);
    n_checks++; if ({d, x} !== {9'd71, 9'd3}) begin n_fail++; $display("FAIL div_500_7 got=q%0d r%0d exp=q71 r3", d, x); end
    n_checks++; if (lat !== 19) begin n_fail++; $display("FAIL div_latency got=%0d exp=19", lat); end
    issue(4'd9, 9'd511, 9'd300, 0, d, x, zf, dz, er, lat);
    n_checks++; if ({d, x} !== {9'd1, 9'd211}) begin n_fail++; $display("FAIL div_511_300 got=q%0d r%0d exp=q1 r211", d, x); end
    issue(4'd9, 9'd77, 9'd0, 0, d, x, zf, dz, er, lat);
    n_checks++; if ({d, x, dz, zf} !== {9'h1FF, 9'd77, 1'b1, 1'b0}) begin n_fail++; $display("FAIL div_by_zero got=%h/%0d dbz%b z%b exp=1ff/77 dbz1 z0", d, x, dz, zf); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_illegal_stall();
    logic [W-1:0] d0, x0; logic z0, e0; int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < LIM) begin @(negedge clk); t++; end
    bus.req_valid = 1'b1; bus.req_op = 4'b0101; bus.req_a = 9'h1AB; bus.req_b = 9'h0CD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_latency got_valid=%b exp=1", bus.resp_valid); end
    n_checks++; if ({bus.resp_err, bus.resp_data, bus.resp_aux, bus.resp_zero} !== {1'b1, 18'd0, 1'b1})
      begin n_fail++; $display("FAIL illegal_resp got=e%b %h/%h z%b exp=e1 0/0 z1", bus.resp_err, bus.resp_data, bus.resp_aux, bus.resp_zero); end
    d0 = bus.resp_data; x0 = bus.resp_aux; z0 = bus.resp_zero; e0 = bus.resp_err;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.resp_data !== d0 ||
          bus.resp_aux !== x0 || bus.resp_zero !== z0 || bus.resp_err !== e0)
        begin n_fail++; $display("FAIL stall_hold cyc%0d got=v%b r%b %h/%h exp=v1 r0 %h/%h", i, bus.resp_valid, bus.req_ready, bus.resp_data, bus.resp_aux, d0, x0); end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_checks++; if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin n_fail++; $display("FAIL after_handshake got=v%b r%b exp=v0 r1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_mid_div();
    logic [W-1:0] d, x; logic zf, dz, er; int lat; int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < LIM) begin @(negedge clk); t++; end
    bus.req_valid = 1'b1; bus.req_op = 4'b1001; bus.req_a = 9'd400; bus.req_b = 9'd13;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.resp_valid, bus.req_ready, ctrl} !== 5'b00000) begin n_fail++; $display("FAIL mid_div_reset got=v%b r%b ctrl=%b exp=v0 r0 ctrl=000", bus.resp_valid, bus.req_ready, ctrl); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin n_fail++; $display("FAIL mid_div_release got=r%b v%b exp=r1 v0", bus.req_ready, bus.resp_valid); end
    issue(4'd2, 9'd2, 9'd2, 0, d, x, zf, dz, er, lat);
    n_checks++; if ({d, lat} !== {9'd4, 32'd2}) begin n_fail++; $display("FAIL add_after_reset got=%0d lat=%0d exp=4 lat=2", d, lat); end
  endtask

  task automatic test_random();
    logic [3:0] op; logic [W-1:0] a, b;
    logic [W-1:0] d, x, ed, ex; logic zf, dz, er, ez, edz, eer; int lat, elat;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
      model(op, a, b, ed, ex, ez, edz, eer, elat);
      issue(op, a, b, $urandom_range(0, 2), d, x, zf, dz, er, lat);
      n_checks++;
      if (d !== ed || x !== ex || zf !== ez || dz !== edz || er !== eer || lat !== elat)
        begin n_fail++; $display("FAIL random op=%b a=%0d b=%0d got=%0d/%0d z%b d%b e%b lat%0d exp=%0d/%0d z%b d%b e%b lat%0d",
                                 op, a, b, d, x, zf, dz, er, lat, ed, ex, ez, edz, eer, elat); end
    end
  endtask

  task automatic test_ctrl_legal();
    n_checks++; if (bad_ctrl !== 0) begin n_fail++; $display("FAIL ula_ctrl_101 got=%0d cycles exp=0", bad_ctrl); end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 4'd0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_direct();
    test_mul();
    test_div();
    test_illegal_stall();
    test_reset_mid_div();
    test_random();
    test_ctrl_legal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
